// File: rtl/autoconfig_ide.sv
// Zorro II autoconfig responder for a single IDE board: serves the $E8xxxx
// configuration nibbles and latches the base address the OS assigns.
module autoconfig_ide #(
  parameter logic [15:0] MANUF_ID   = 16'h07DB,
  parameter logic [7:0]  PRODUCT_ID = 8'h01,
  parameter logic [31:0] SERIAL_NO  = 32'h00000001,
  parameter logic [15:0] DIAG_VEC   = 16'h0000
) (
  input  logic       CLKCPU,
  input  logic       RESET_n,
  input  logic [7:0] A_HIGH,
  input  logic [5:0] A_LOW,
  input  logic [3:0] D_IN,
  input  logic       RW_n,
  input  logic       AS_CPU_n,
  input  logic       CFGIN_n,
  output logic [3:0] D_OUT,
  output logic       D_OE,
  output logic       DTACK_n,
  output logic       CFGOUT_n,
  output logic [7:0] BASE_IDE,
  output logic       IDE_CONFIGURED_n
);

  typedef enum logic [1:0] {UNCONF, ACTIVE, CONFIGURED, SHUTUP} state_t;

  localparam logic [5:0] IDX_BASE_HI = 6'h24;  // byte offset $48
  localparam logic [5:0] IDX_BASE_LO = 6'h25;  // byte offset $4A
  localparam logic [5:0] IDX_SHUTUP  = 6'h26;  // byte offset $4C

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_cnt;
  logic       r_dtack_n;
  logic       r_cfgout_n;
  logic [3:0] r_base_lo;
  logic [7:0] r_base_ide;
  logic       r_ide_conf_n;
  logic       w_hit;
  logic       w_ack_edge;
  logic       w_wr_commit;

  // Nibble index is A[6:1]; only er_Type (idx 0/1) and the register area
  // at $40 and above are returned uninverted.
  function automatic logic [3:0] f_rom_nibble(input logic [5:0] idx);
    logic [3:0] raw;
    raw = 4'h0;
    case (idx)
      6'd0:  raw = 4'hD;
      6'd1:  raw = 4'h1;
      6'd2:  raw = PRODUCT_ID[7:4];
      6'd3:  raw = PRODUCT_ID[3:0];
      6'd8:  raw = MANUF_ID[15:12];
      6'd9:  raw = MANUF_ID[11:8];
      6'd10: raw = MANUF_ID[7:4];
      6'd11: raw = MANUF_ID[3:0];
      6'd12: raw = SERIAL_NO[31:28];
      6'd13: raw = SERIAL_NO[27:24];
      6'd14: raw = SERIAL_NO[23:20];
      6'd15: raw = SERIAL_NO[19:16];
      6'd16: raw = SERIAL_NO[15:12];
      6'd17: raw = SERIAL_NO[11:8];
      6'd18: raw = SERIAL_NO[7:4];
      6'd19: raw = SERIAL_NO[3:0];
      6'd20: raw = DIAG_VEC[15:12];
      6'd21: raw = DIAG_VEC[11:8];
      6'd22: raw = DIAG_VEC[7:4];
      6'd23: raw = DIAG_VEC[3:0];
      default: raw = 4'h0;
    endcase
    if (idx < 6'd2 || idx >= 6'd32) return raw;
    return ~raw;
  endfunction

  // CFGIN_n is part of the decode so a chain drop releases the bus at once.
  assign w_hit       = (r_state == ACTIVE) && !CFGIN_n && (A_HIGH == 8'hE8) && !AS_CPU_n;
  assign w_ack_edge  = w_hit && (r_cnt == 2'd1);
  assign w_wr_commit = w_ack_edge && !RW_n;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      UNCONF: if (!CFGIN_n) w_state_nxt = ACTIVE;
      ACTIVE: begin
        if (CFGIN_n)                                      w_state_nxt = UNCONF;
        else if (w_wr_commit && (A_LOW == IDX_BASE_HI))   w_state_nxt = CONFIGURED;
        else if (w_wr_commit && (A_LOW == IDX_SHUTUP))    w_state_nxt = SHUTUP;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state      <= UNCONF;
      r_cnt        <= 2'd0;
      r_dtack_n    <= 1'b1;
      r_cfgout_n   <= 1'b1;
      r_base_lo    <= 4'h0;
      r_base_ide   <= 8'h00;
      r_ide_conf_n <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cfgout_n <= !((r_state == CONFIGURED) || (r_state == SHUTUP));
      // r_cnt: 0 = idle, 1 = strobe seen, 2 = acknowledged (no re-commit)
      if (AS_CPU_n) begin
        r_cnt     <= 2'd0;
        r_dtack_n <= 1'b1;
      end else if (w_hit && (r_cnt == 2'd0)) begin
        r_cnt <= 2'd1;
      end else if (w_ack_edge) begin
        r_cnt     <= 2'd2;
        r_dtack_n <= 1'b0;
      end
      if (w_wr_commit && (A_LOW == IDX_BASE_LO)) r_base_lo <= D_IN;
      if (w_wr_commit && (A_LOW == IDX_BASE_HI)) begin
        r_base_ide   <= {D_IN, r_base_lo};
        r_ide_conf_n <= 1'b0;
      end
    end
  end

  assign D_OE             = w_hit && RW_n;
  assign D_OUT            = D_OE ? f_rom_nibble(A_LOW) : 4'h0;
  assign DTACK_n          = r_dtack_n;
  assign CFGOUT_n         = r_cfgout_n;
  assign BASE_IDE         = r_base_ide;
  assign IDE_CONFIGURED_n = r_ide_conf_n;

endmodule
